ksa: RTL
========

# ksa

Key-scheduling engine for the ARC4 datapath. It runs once the S memory has been filled with the identity permutation, reads that memory back, and applies the ARC4 key schedule in place. For each i from 0 to 255 it computes j = (j + S[i] + key[i mod 3]) mod 256 and then swaps S[i] and S[j]. It uses the same single-port 256×8 S memory and the same en/rdy start handshake as the identity-fill block, and adds the read path (rddata) to that memory interface.

## Interface
Parameters: none. Key length and memory depth are fixed constants in the shared package.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  24  secret key; key[23:16] is key byte 0, key[15:8] byte 1, key[7:0] byte 2.
- addr  out  8  S memory address.
- rddata  in  8  S memory read data; valid the cycle after addr is presented (synchronous read, 1-cycle latency).
- wrdata  out  8  S memory write data.
- wren  out  1  S memory write enable.

## Operation
- Reset values: rdy=1, addr=0, wrdata=0, wren=0. Internal i=0, j=0, state IDLE.
- IDLE: rdy=1, wren=0. If en=1 on a clock edge, the block:
  - registers key into an internal copy,
  - clears i and j,
  - goes to READ_I and drops rdy on that same edge.
- READ_I: addr=i, wren=0.
- READ_J:
  - rddata holds S[i]; register it as si.
  - Compute jn = j + si + keybyte(i mod 3), mod 256; register it as j.
  - Drive addr=jn, wren=0.
- WRITE_I:
  - rddata holds S[j]; register it as sj.
  - Drive addr=i, wrdata=S[j] (the current rddata), wren=1.
- WRITE_J: addr=j, wrdata=si, wren=1. Then:
  - if i=255, go to IDLE and raise rdy;
  - otherwise increment i and go to READ_I.
- All arithmetic is 8-bit and wraps modulo 256. i mod 3 comes from a 2-bit counter that wraps 2→0, not from a divider.
- i==j: both writes go to the same address with the same value; the result is correct and no special case is needed.
- en is ignored in every state except IDLE. key changes after the accept edge have no effect.
- rst_n low mid-operation:
  - immediate return to IDLE with reset output values;
  - the memory contents are left partially permuted;
  - a later en restarts from i=0, j=0.

## Timing
- 4 cycles per iteration (READ_I, READ_J, WRITE_I, WRITE_J); 256 iterations.
- rdy is low for exactly 1024 cycles. It rises on the edge that ends the final WRITE_J, i.e. 1024 edges after the accept edge.
- The earliest new accept is the edge after rdy rises. Back-to-back runs operate on the already permuted S.
- wren is high only in WRITE_I and WRITE_J. Exactly 512 writes per run.
- Read-after-write: a READ_I that follows a WRITE_J presents its address one cycle after the write edge. The memory returns the new data, so no bypass is required.

## Structure
- Shared package arc4_pkg holds:
  - the state enum (IDLE, READ_I, READ_J, WRITE_I, WRITE_J);
  - localparams KEY_BYTES=3 and S_DEPTH=256;
  - a function that selects key byte n from the 24-bit key.
- Single FSM module with no sub-module. The key-byte mux and mod-3 counter are inline.
- Target size 120–200 lines.

## Test plan
- Reset: assert rst_n=0 with no clock edges → rdy=1, wren=0, addr=0, wrdata=0.
- Memory model preloaded with S[k]=k, key=24'h000000:
  - first six writes are (addr,data) = (0,0), (0,0), (1,1), (1,1), (2,3), (3,2);
  - final S matches the behavioural ARC4 KSA model at all 256 locations.
- Identity S, key=24'h010203, iteration 0: READ_J drives addr=1; WRITE_I writes addr 0 data 1; WRITE_J writes addr 1 data 0.
- Handshake:
  - en held high throughout → rdy low for exactly 1024 cycles and 512 wren pulses;
  - a second run starts only on the edge after rdy rises;
  - key toggled while busy → final S is unchanged versus the run with a stable key.
- Reset mid-run: pull rst_n low at cycle 500 → rdy=1 and wren=0 immediately. Then reload identity S and start with key=24'h000000 → final S matches the model.
- Random keys (≥20) against the behavioural model: full S equality after each run.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 datapath blocks: FSM states, sizing
// constants and the key-byte selector used by the key schedule.
package arc4_pkg;

    localparam int KEY_BYTES = 3;
    localparam int S_DEPTH   = 256;

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        READ_J,
        WRITE_I,
        WRITE_J
    } state_e;

    // Byte 0 is the most significant byte of the 24-bit key.
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] n);
        case (n)
            2'd0:    return key[23:16];
            2'd1:    return key[15:8];
            default: return key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling engine: permutes the S memory in place, four cycles per
// index (read S[i], read S[j], write S[i], write S[j]).
module ksa
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    state_e      state_q;
    logic [7:0]  i_q;
    logic [7:0]  j_q;
    logic [7:0]  si_q;
    logic [1:0]  kidx_q;
    logic [23:0] key_q;
    logic [7:0]  j_d;

    // In READ_J rddata carries S[i]; the new j is needed combinationally as the next read address.
    assign j_d = j_q + rddata + key_byte(key_q, kidx_q);

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            kidx_q  <= 2'd0;
            key_q   <= 24'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        key_q   <= key;
                        i_q     <= 8'd0;
                        j_q     <= 8'd0;
                        kidx_q  <= 2'd0;
                        state_q <= READ_I;
                    end
                end
                READ_I: begin
                    state_q <= READ_J;
                end
                READ_J: begin
                    si_q    <= rddata;
                    j_q     <= j_d;
                    state_q <= WRITE_I;
                end
                WRITE_I: begin
                    state_q <= WRITE_J;
                end
                WRITE_J: begin
                    if (i_q == 8'(S_DEPTH - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        kidx_q  <= (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
                        state_q <= READ_I;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The S[j] write data and the j read address come straight from rddata,
    // so the memory-side outputs are decoded from the state rather than registered.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        rdy    = 1'b0;
        addr   = 8'd0;
        wrdata = 8'd0;
        wren   = 1'b0;
        case (state_q)
            IDLE:    rdy = 1'b1;
            READ_I:  addr = i_q;
            READ_J:  addr = j_d;
            WRITE_I: begin
                addr   = i_q;
                wrdata = rddata;
                wren   = 1'b1;
            end
            WRITE_J: begin
                addr   = j_q;
                wrdata = si_q;
                wren   = 1'b1;
            end
            default: rdy = 1'b0;
        endcase
    end

endmodule
